lfsr_rand: RTL and testbench

Parametrised Fibonacci LFSR random source. It generalises the fixed 11-bit generator in width, tap set, seed and bits advanced per cycle, and adds run-time seed loading. It also adds a bounded-draw engine: a request/response handshake returns a random value below a caller-supplied bound, using rejection sampling with a retry limit. Game logic uses it for spawn positions, AI choices and effects timing.

---
 rtl/lfsr_rand.sv | 137 +++++++++++++
 tb/tb_lfsr_rand.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rand.sv
// lfsr_rand: parametrised Fibonacci LFSR with run-time seeding and a
// bounded-draw engine (rejection sampling with a retry limit).
module lfsr_rand #(
    parameter int unsigned             WIDTH     = 11,
    parameter logic [WIDTH-1:0]        TAPS      = 11'h087,
    parameter logic [WIDTH-1:0]        SEED      = 11'h25D,
    parameter int unsigned             STEPS     = 1,
    parameter int unsigned             OUT_W     = 4,
    parameter int unsigned             MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_enable,
    input  logic              load,
    input  logic [WIDTH-1:0]  seed_in,
    output logic [WIDTH-1:0]  count,
    input  logic              req_valid,
    input  logic [OUT_W-1:0]  req_bound,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [OUT_W-1:0]  rsp_data,
    output logic              rsp_fail,
    input  logic              rsp_ready
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_fsm;
    logic [WIDTH-1:0]   r_state;
    logic [OUT_W-1:0]   r_bound;
    logic [TRY_W-1:0]   r_tries;

    logic [WIDTH-1:0]   w_adv;
    logic [OUT_W-1:0]   w_cand;
    logic               w_cand_ok;
    logic [TRY_W-1:0]   w_tries_nxt;
    logic [WIDTH-1:0]   w_load_val;

    // One Fibonacci shift; the NOR term lets the all-zero state escape.
    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] s);
        logic fb;
        fb = (^(s & TAPS)) ^ (~|s[WIDTH-1:1]);
        return {fb, s[WIDTH-1:1]};
    endfunction

    // STEPS chained shifts evaluated in a single cycle.
    always_comb begin
        w_adv = r_state;
        for (int unsigned k = 0; k < STEPS; k++) begin
            w_adv = f_shift(w_adv);
        end
    end

    // Candidate evaluation for the draw engine; bound of zero means full range.
    always_comb begin
        w_cand      = w_adv[OUT_W-1:0];
        w_cand_ok   = (r_bound == '0) || (w_cand < r_bound);
        w_tries_nxt = TRY_W'(r_tries + TRY_W'(1));
        w_load_val  = (seed_in == '0) ? SEED : seed_in;
    end

    // LFSR state: rst > load > draw advance > idle shift_enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (load) begin
            r_state <= w_load_val;
        end else if (r_fsm == ST_DRAW) begin
            r_state <= w_adv;
        end else if ((r_fsm == ST_IDLE) && shift_enable) begin
            r_state <= w_adv;
        end
    end

    // Draw FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm     <= ST_IDLE;
            r_bound   <= '0;
            r_tries   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_fail  <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_bound   <= req_bound;
                        r_tries   <= '0;
                        req_ready <= 1'b0;
                        r_fsm     <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    // A concurrent load replaces this cycle's advance, so no candidate is consumed.
                    if (!load) begin
                        r_tries <= w_tries_nxt;
                        if (w_cand_ok) begin
                            rsp_data  <= w_cand;
                            rsp_fail  <= 1'b0;
                            rsp_valid <= 1'b1;
                            r_fsm     <= ST_DONE;
                        end else if (w_tries_nxt == TRY_LAST) begin
                            rsp_data  <= '0;
                            rsp_fail  <= 1'b1;
                            rsp_valid <= 1'b1;
                            r_fsm     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        r_fsm     <= ST_IDLE;
                    end
                end
                default: begin
                    r_fsm     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign count = r_state;

endmodule

// File: tb/tb_lfsr_rand.sv
// Bench for lfsr_rand: directed steps plus randomized idle and draw traffic
// checked against an arithmetic reference model.
module tb_lfsr_rand;

    localparam logic [10:0] TAPS = 11'h087;
    localparam logic [10:0] SEED = 11'h25D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic        a_se = 0, a_ld = 0, a_rv = 0, a_rr = 0;
    logic [10:0] a_seed = '0;
    logic [3:0]  a_rb = '0;
    logic [10:0] a_count;
    logic        a_req_ready, a_rsp_valid, a_rsp_fail;
    logic [3:0]  a_rsp_data;
    // DUT B: MAX_TRIES=2
    logic        b_rv = 0, b_rr = 0;
    logic [3:0]  b_rb = '0;
    logic [10:0] b_count;
    logic        b_req_ready, b_rsp_valid, b_rsp_fail;
    logic [3:0]  b_rsp_data;
    // DUT C: STEPS=3
    logic        c_se = 0;
    logic [10:0] c_count;
    logic        c_req_ready, c_rsp_valid, c_rsp_fail;
    logic [3:0]  c_rsp_data;

    lfsr_rand u_a (
        .clk(clk), .rst(rst), .shift_enable(a_se), .load(a_ld), .seed_in(a_seed),
        .count(a_count), .req_valid(a_rv), .req_bound(a_rb), .req_ready(a_req_ready),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_fail(a_rsp_fail), .rsp_ready(a_rr)
    );

    lfsr_rand #(.MAX_TRIES(2)) u_b (
        .clk(clk), .rst(rst), .shift_enable(1'b0), .load(1'b0), .seed_in(11'h000),
        .count(b_count), .req_valid(b_rv), .req_bound(b_rb), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_fail(b_rsp_fail), .rsp_ready(b_rr)
    );

    lfsr_rand #(.STEPS(3)) u_c (
        .clk(clk), .rst(rst), .shift_enable(c_se), .load(1'b0), .seed_in(11'h000),
        .count(c_count), .req_valid(1'b0), .req_bound(4'h0), .req_ready(c_req_ready),
        .rsp_valid(c_rsp_valid), .rsp_data(c_rsp_data), .rsp_fail(c_rsp_fail), .rsp_ready(1'b0)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [10:0] ma;

    // Reference: one shift computed from parity of tapped bits and a zero test of the upper bits.
    function automatic logic [10:0] m_shift(input logic [10:0] x);
        int par, zero_hi, fb;
        par     = $countones(x & TAPS) % 2;
        zero_hi = ((x >> 1) == 0) ? 1 : 0;
        fb      = par ^ zero_hi;
        return 11'((fb << 10) + (x >> 1));
    endfunction

    function automatic logic [10:0] m_adv(input logic [10:0] x, input int n);
        logic [10:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = m_shift(y);
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one draw on DUT A, wait for the response, hold it, then hand it off.
    task automatic draw_a(input logic [3:0] bound, input int hold);
        int t_exp, lat;
        logic [3:0] d_exp;
        logic f_exp;
        logic [10:0] s;
        s = ma;
        t_exp = 0; d_exp = 0; f_exp = 0;
        for (int t = 1; t <= 8; t++) begin
            s = m_adv(s, 1);
            t_exp = t;
            if (bound == 0 || int'(s % 16) < int'(bound)) begin
                d_exp = 4'(s % 16); f_exp = 0; break;
            end
            if (t == 8) begin d_exp = 0; f_exp = 1; end
        end
        chk("a_req_ready_pre", 32'(a_req_ready), 32'd1);
        a_rv = 1; a_rb = bound;
        step();
        a_rv = 0;
        lat = 1;
        while (!a_rsp_valid && lat < 20) begin
            a_se = 1'($urandom % 2);
            step();
            lat++;
        end
        a_se = 0;
        ma = s;
        chk("a_rsp_valid", 32'(a_rsp_valid), 32'd1);
        chk("a_latency", 32'(lat), 32'(t_exp + 1));
        chk("a_rsp_data", 32'(a_rsp_data), 32'(d_exp));
        chk("a_rsp_fail", 32'(a_rsp_fail), 32'(f_exp));
        chk("a_count_draw", 32'(a_count), 32'(ma));
        for (int h = 0; h < hold; h++) begin
            a_se = 1;
            step();
            chk("a_hold_valid", 32'(a_rsp_valid), 32'd1);
            chk("a_hold_data", 32'(a_rsp_data), 32'(d_exp));
            chk("a_hold_fail", 32'(a_rsp_fail), 32'(f_exp));
            chk("a_hold_count", 32'(a_count), 32'(ma));
            chk("a_hold_ready", 32'(a_req_ready), 32'd0);
        end
        a_se = 0;
        a_rr = 1;
        step();
        a_rr = 0;
        chk("a_post_valid", 32'(a_rsp_valid), 32'd0);
        chk("a_post_ready", 32'(a_req_ready), 32'd1);
        chk("a_post_count", 32'(a_count), 32'(ma));
    endtask

    initial begin
        logic [10:0] sd;
        int lat;

        // Reset
        rst = 1; step(); step(); rst = 0;
        ma = SEED;
        chk("rst_count", 32'(a_count), 32'(ma));
        chk("rst_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(a_rsp_data), 32'd0);
        chk("rst_rsp_fail", 32'(a_rsp_fail), 32'd0);
        chk("rst_b_count", 32'(b_count), 32'(SEED));
        chk("rst_c_count", 32'(c_count), 32'(SEED));

        // Two single-shift advances
        a_se = 1;
        step(); ma = m_adv(ma, 1); chk("se1_count", 32'(a_count), 32'(ma));
        step(); ma = m_adv(ma, 1); chk("se2_count", 32'(a_count), 32'(ma));
        a_se = 0;

        // Load 1 then walk through zero
        a_ld = 1; a_seed = 11'h001; step(); a_ld = 0; ma = 11'h001;
        chk("ld1_count", 32'(a_count), 32'(ma));
        a_se = 1;
        step(); ma = m_adv(ma, 1); chk("zero_count", 32'(a_count), 32'(ma));
        step(); ma = m_adv(ma, 1); chk("escape_count", 32'(a_count), 32'(ma));
        a_se = 0;
        a_ld = 1; a_seed = 11'h000; step(); a_ld = 0; ma = SEED;
        chk("ld0_count", 32'(a_count), 32'(ma));

        // Random idle traffic: shift_enable and loads (load wins)
        for (int i = 0; i < 40; i++) begin
            a_se = 1'($urandom % 2);
            a_ld = (($urandom % 8) == 0);
            sd = (($urandom % 4) == 0) ? 11'h000 : 11'($urandom_range(0, 2047));
            a_seed = sd;
            step();
            if (a_ld) ma = (sd == 0) ? SEED : sd;
            else if (a_se) ma = m_adv(ma, 1);
            chk("idle_rand_count", 32'(a_count), 32'(ma));
        end
        a_se = 0; a_ld = 0;

        // Directed draw from reset: bound 10, held 5 cycles
        rst = 1; step(); rst = 0; ma = SEED;
        draw_a(4'd10, 5);

        // Random draws with random bounds and hold times
        for (int i = 0; i < 25; i++) begin
            draw_a(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        // Retry limit on DUT B (MAX_TRIES=2): bound 1 from reset
        rst = 1; step(); rst = 0; ma = SEED;
        b_rv = 1; b_rb = 4'd1; step(); b_rv = 0;
        lat = 1;
        while (!b_rsp_valid && lat < 20) begin step(); lat++; end
        chk("b_rsp_valid", 32'(b_rsp_valid), 32'd1);
        chk("b_latency", 32'(lat), 32'd3);
        chk("b_rsp_data", 32'(b_rsp_data), 32'd0);
        chk("b_rsp_fail", 32'(b_rsp_fail), 32'd1);
        chk("b_count", 32'(b_count), 32'(m_adv(SEED, 2)));
        b_rr = 1; step(); b_rr = 0;
        chk("b_post_ready", 32'(b_req_ready), 32'd1);

        // STEPS=3 advance on DUT C
        c_se = 1; step(); c_se = 0;
        chk("c_steps3_count", 32'(c_count), 32'(m_adv(SEED, 3)));
        chk("c_idle_ready", 32'(c_req_ready), 32'd1);
        chk("c_idle_valid", 32'(c_rsp_valid), 32'd0);

        // Reset mid-draw on DUT A drops the pending draw
        ma = SEED;
        a_rv = 1; a_rb = 4'd1; step(); a_rv = 0;
        step();
        chk("mid_ready", 32'(a_req_ready), 32'd0);
        chk("mid_count", 32'(a_count), 32'(m_adv(SEED, 1)));
        rst = 1; step(); rst = 0;
        chk("rstdraw_valid", 32'(a_rsp_valid), 32'd0);
        chk("rstdraw_ready", 32'(a_req_ready), 32'd1);
        chk("rstdraw_count", 32'(a_count), 32'(SEED));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
